// File: rtl/sram_controller.sv
// MEM-stage data-memory controller: turns one 32-bit load/store into two
// sequenced halfword accesses on a 16-bit async SRAM, freezing the pipeline meanwhile.
module sram_controller #(
    parameter int          ACCESS_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR     = 32'd1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] writeData,
    output logic [31:0] readData,
    output logic        ready,
    inout  wire  [15:0] SRAM_DQ,
    output logic [17:0] SRAM_ADDR,
    output logic        SRAM_WE_N,
    output logic        SRAM_OE_N,
    output logic        SRAM_CE_N,
    output logic        SRAM_UB_N,
    output logic        SRAM_LB_N
);

    localparam int PW = (ACCESS_CYCLES < 4) ? 2 : $clog2(ACCESS_CYCLES);
    localparam logic [PW-1:0] LAST_PHASE = PW'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

    state_t      state_reg;
    logic [PW-1:0] phase_reg;
    logic        is_write_reg;
    logic [15:0] wdata_hi_reg;
    logic [15:0] dq_out_reg;
    logic        dq_oe_reg;
    logic [17:0] sram_addr_reg;
    logic        we_n_reg;
    logic        oe_n_reg;
    logic [31:0] read_data_reg;

    logic [31:0] off;
    logic        request;
    logic        unused_off_bits;

    // Only the word index of the rebased address reaches the SRAM.
    assign off             = address - BASE_ADDR;
    assign unused_off_bits = ^{off[31:19], off[1:0]};
    assign request         = rd_en | wr_en;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            phase_reg     <= '0;
            is_write_reg  <= 1'b0;
            wdata_hi_reg  <= '0;
            dq_out_reg    <= '0;
            dq_oe_reg     <= 1'b0;
            sram_addr_reg <= '0;
            we_n_reg      <= 1'b1;
            oe_n_reg      <= 1'b1;
            read_data_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (request) begin
                        state_reg     <= LO;
                        phase_reg     <= '0;
                        is_write_reg  <= wr_en;
                        wdata_hi_reg  <= writeData[31:16];
                        sram_addr_reg <= {off[18:2], 1'b0};
                        if (wr_en) begin
                            dq_out_reg <= writeData[15:0];
                            dq_oe_reg  <= 1'b1;
                            we_n_reg   <= 1'b0;
                        end else begin
                            oe_n_reg   <= 1'b0;
                        end
                    end
                end
                LO: begin
                    if (phase_reg == LAST_PHASE) begin
                        state_reg        <= HI;
                        phase_reg        <= '0;
                        sram_addr_reg[0] <= 1'b1;
                        if (is_write_reg) begin
                            dq_out_reg <= wdata_hi_reg;
                        end else begin
                            read_data_reg[15:0] <= SRAM_DQ;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                HI: begin
                    if (phase_reg == LAST_PHASE) begin
                        state_reg <= DONE;
                        phase_reg <= '0;
                        dq_oe_reg <= 1'b0;
                        we_n_reg  <= 1'b1;
                        oe_n_reg  <= 1'b1;
                        if (!is_write_reg) begin
                            read_data_reg[31:16] <= SRAM_DQ;
                        end
                    end else begin
                        phase_reg <= phase_reg + 1'b1;
                    end
                end
                default: begin
                    // A request present during DONE is picked up from IDLE next cycle.
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign ready     = (state_reg == DONE) || ((state_reg == IDLE) && !request);
    assign readData  = read_data_reg;
    assign SRAM_DQ   = dq_oe_reg ? dq_out_reg : 16'bz;
    assign SRAM_ADDR = sram_addr_reg;
    assign SRAM_WE_N = we_n_reg;
    assign SRAM_OE_N = oe_n_reg;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;

endmodule
